ex_muldiv_unit: RTL and testbench

//  Iterative radix-2 multiply/divide unit beside the EX stage ALU. Executes MULT/MULTU/DIV/DIVU

---
 rtl/ex_muldiv_if.sv | 25 ++
 rtl/ex_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Handshake and result bundle between the EX stage and the iterative multiply/divide unit.
interface ex_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] opa_i;
  logic [DATA_W-1:0] opb_i;
  logic              annul_i;
  logic              stallreq_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              div_by_zero_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, annul_i,
    input  stallreq_o, done_o, hi_o, lo_o, div_by_zero_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, annul_i,
    output stallreq_o, done_o, hi_o, lo_o, div_by_zero_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit producing HI/LO, stalling EX while busy.
// Optional EX_MULDIV_ZERO_SKIP_EN: zero operands complete in one cycle with a zero result.
module ex_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              is_div;
  logic              neg_lo;
  logic              neg_hi;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] work_hi;
  logic [DATA_W-1:0] work_lo;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic              done_reg;
  logic              dbz_reg;

  logic              start_div;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              accept;

  assign start_div = bus.op_i[1];
  assign a_neg     = ~bus.op_i[0] & bus.opa_i[DATA_W-1];
  assign b_neg     = ~bus.op_i[0] & bus.opb_i[DATA_W-1];
  assign a_mag     = a_neg ? -bus.opa_i : bus.opa_i;
  assign b_mag     = b_neg ? -bus.opb_i : bus.opb_i;
  assign accept    = bus.start_i & ~bus.annul_i;

`ifdef EX_MULDIV_ZERO_SKIP_EN
  logic skip;
  assign skip = start_div ? (bus.opa_i == '0 && bus.opb_i != '0)
                          : (bus.opa_i == '0 || bus.opb_i == '0);
`endif

  // Both algorithms share work_hi (partial product / remainder) and work_lo (multiplier / quotient).
  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic                ge;
  logic [DATA_W-1:0]   step_hi;
  logic [DATA_W-1:0]   step_lo;
  logic [2*DATA_W-1:0] prod_raw;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  always_comb begin
    add_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_b} : '0);
    shifted  = {work_hi, work_lo[DATA_W-1]};
    diff     = shifted - {1'b0, mag_b};
    ge       = ~diff[DATA_W];
    if (is_div) begin
      step_hi = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      step_lo = {work_lo[DATA_W-2:0], ge};
    end else begin
      step_hi = add_sum[DATA_W:1];
      step_lo = {add_sum[0], work_lo[DATA_W-1:1]};
    end
    prod_raw = {step_hi, step_lo};
    prod_fix = neg_lo ? -prod_raw : prod_raw;
    if (is_div) begin
      fix_hi = neg_hi ? -step_hi : step_hi;
      fix_lo = neg_lo ? -step_lo : step_lo;
    end else begin
      fix_hi = prod_fix[2*DATA_W-1:DATA_W];
      fix_lo = prod_fix[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      mag_b    <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (accept) begin
            if (start_div && bus.opb_i == '0) begin
              state    <= DONE;
              done_reg <= 1'b1;
              dbz_reg  <= 1'b1;
              hi_reg   <= bus.opa_i;
              lo_reg   <= '1;
            end
`ifdef EX_MULDIV_ZERO_SKIP_EN
            else if (skip) begin
              state    <= DONE;
              done_reg <= 1'b1;
              dbz_reg  <= 1'b0;
              hi_reg   <= '0;
              lo_reg   <= '0;
            end
`endif
            else begin
              state   <= BUSY;
              cnt     <= '0;
              is_div  <= start_div;
              neg_lo  <= a_neg ^ b_neg;
              neg_hi  <= start_div & a_neg;
              mag_b   <= b_mag;
              work_hi <= '0;
              work_lo <= a_mag;
            end
          end
        end
        BUSY: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            work_hi <= step_hi;
            work_lo <= step_lo;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST_ITER) begin
              state    <= DONE;
              done_reg <= 1'b1;
              dbz_reg  <= 1'b0;
              hi_reg   <= fix_hi;
              lo_reg   <= fix_lo;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          done_reg <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stallreq_o    = ~rst & ((state == IDLE & accept) | (state == BUSY));
  assign bus.done_o        = done_reg;
  assign bus.hi_o          = hi_reg;
  assign bus.lo_o          = lo_reg;
  assign bus.div_by_zero_o = dbz_reg;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO/flag queued at accept, checked on done_o.
module tb_ex_muldiv_unit;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  logic        last_dbz = 1'b0;
  logic [64:0] exp_q[$];

  ex_muldiv_if #(.DATA_W(32)) bus();

  ex_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model built on native SV arithmetic: {dbz, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[1] && b == 0) return 1;
`ifdef EX_MULDIV_ZERO_SKIP_EN
    if (op[1] && a == 0) return 1;
    if (!op[1] && (a == 0 || b == 0)) return 1;
`endif
    return 33;
  endfunction

  always @(negedge clk) begin
    if (bus.done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("hi", 64'(bus.hi_o), 64'(e[63:32]));
        check("lo", 64'(bus.lo_o), 64'(e[31:0]));
        check("div_by_zero", 64'(bus.div_by_zero_o), 64'(e[64]));
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [64:0] exp);
    int   lat;
    logic stall_ok;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.opa_i   = a;
    bus.opb_i   = b;
    #1;
    check("stall_accept", 64'(bus.stallreq_o), 64'd1);
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start_i = 1'b0;
    lat = 1;
    stall_ok = 1'b1;
    while (!bus.done_o && lat < 100) begin
      #1;
      if (!bus.stallreq_o) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_latency(op, a, b)));
    check("stall_busy", 64'(stall_ok), 64'd1);
    check("stall_in_done", 64'(bus.stallreq_o), 64'd0);
    last_dbz = exp[64];
    last_hi  = exp[63:32];
    last_lo  = exp[31:0];
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d", op, a, b,
             bus.hi_o, bus.lo_o, bus.div_by_zero_o, lat);
  endtask

  task automatic quiet_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.opa_i   = '0;
    bus.opb_i   = '0;
    bus.annul_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.start_i = 1'b1;
    #1;
    check("reset_stall", 64'(bus.stallreq_o), 64'd0);
    check("reset_hi", 64'(bus.hi_o), 64'd0);
    check("reset_lo", 64'(bus.lo_o), 64'd0);
    check("reset_done", 64'(bus.done_o), 64'd0);
    check("reset_dbz", 64'(bus.div_by_zero_o), 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    run_op(2'b00, -32'sd3, 32'd7, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op(2'b10, -32'sd7, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(2'b11, 32'd100, 32'd0, {1'b1, 32'd100, 32'hFFFF_FFFF});
    run_op(2'b11, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});

    // Annul a MULTU in cycle N+10: no completion, results unchanged.
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b01; bus.opa_i = 32'd5; bus.opb_i = 32'd6;
    @(negedge clk);
    bus.start_i = 1'b0;
    quiet_cycles(9);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    #1;
    check("annul_stall", 64'(bus.stallreq_o), 64'd0);
    quiet_cycles(40);
    check("annul_hi", 64'(bus.hi_o), 64'(last_hi));
    check("annul_lo", 64'(bus.lo_o), 64'(last_lo));
    $display("annul of MULTU 5*6 -> hi=%h lo=%h", bus.hi_o, bus.lo_o);

    // start_i together with annul_i in IDLE is discarded.
    @(negedge clk);
    bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.op_i = 2'b01; bus.opa_i = 32'd3; bus.opb_i = 32'd3;
    #1;
    check("start_annul_stall", 64'(bus.stallreq_o), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    #1;
    check("start_annul_idle", 64'(bus.stallreq_o), 64'd0);
    quiet_cycles(40);
    $display("start+annul in IDLE -> discarded");

    // Reset in cycle N+5 of a DIV aborts it and clears the outputs.
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b10; bus.opa_i = -32'sd100; bus.opb_i = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    quiet_cycles(4);
    rst = 1'b1;
    #1;
    check("rst_stall", 64'(bus.stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_hi", 64'(bus.hi_o), 64'd0);
    check("rst_lo", 64'(bus.lo_o), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero_o), 64'd0);
    quiet_cycles(40);
    $display("reset during DIV -> hi=%h lo=%h", bus.hi_o, bus.lo_o);
    run_op(2'b11, 32'd9, 32'd4, {1'b0, 32'd1, 32'd2});

    run_op(2'b00, 32'd0, 32'd1234, {1'b0, 32'd0, 32'd0});
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0, 32'h8000_0000});

    // Model-checked patterns: signed/unsigned edges, zero operands, then random.
    begin
      logic [1:0]  ops[8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
      logic [31:0] as[8]  = '{32'h8000_0000, 32'h0, 32'd0, 32'd0, 32'd7, 32'hFFFF_FFFF, 32'd12345, 32'h7FFF_FFFF};
      logic [31:0] bs[8]  = '{32'h8000_0000, 32'd77, 32'd5, 32'd3, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'hFFFF_FFFF};
      for (int i = 0; i < 8; i++) run_op(ops[i], as[i], bs[i], model(ops[i], as[i], bs[i]));
    end
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom();
      b  = (i % 3 == 2) ? 32'($urandom_range(1, 255)) : $urandom();
      run_op(op, a, b, model(op, a, b));
    end

    quiet_cycles(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
